// File: rtl/timing_monitor_pkg.sv
// Shared timing-bus definitions: state encodings and bus width, common with the sequencer.
// No logic; constants and one helper only.
// No flow control.
package timing_monitor_pkg;

    // Number of timing steps on the one-hot bus (T0..T15).
    localparam int NSTEPS = 16;

    // Monitor state encodings (legacy-compatible 2-bit codes).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Successor of a step index; 15 wraps back to 0.
    function automatic logic [3:0] next_step(input logic [3:0] s);
        return s + 4'd1;
    endfunction

endpackage

// File: rtl/timing_monitor_if.sv
// Timing-bus bundle between the sequencer side and the timing monitor.
// No latency of its own; wires only.
// No backpressure: the bus is sampled every enabled cycle.
interface timing_monitor_if #(
    parameter int CW = 8
);
    logic          en;
    logic [15:0]   t_in;
    logic          jump_ok;
    logic          err_clr;
    logic [3:0]    step;
    logic          valid;
    logic          err_onehot;
    logic          err_seq;
    logic [CW-1:0] instr_count;
    logic          clr_req;

    modport master (
        output en, t_in, jump_ok, err_clr,
        input  step, valid, err_onehot, err_seq, instr_count, clr_req
    );

    modport slave (
        input  en, t_in, jump_ok, err_clr,
        output step, valid, err_onehot, err_seq, instr_count, clr_req
    );
endinterface

// File: rtl/timing_monitor_onehot_enc16.sv
// Encodes a 16-bit one-hot timing bus to a 4-bit index and flags zero/multi-hot inputs.
// Purely combinational, zero latency.
// No flow control.
module onehot_enc16 (
    input  logic [15:0] d,
    output logic [3:0]  idx,
    output logic        is_zero,
    output logic        is_multi
);

    // OR together the indices of set bits; exact whenever exactly one bit is set.
    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (d[i]) begin
                idx = idx | 4'(i);
            end
        end
    end

    assign is_zero  = (d == 16'd0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign is_multi = ((d & (d - 16'd1)) != 16'd0);

endmodule

// File: rtl/timing_monitor.sv
// Checks the sequencer's one-hot timing bus, re-encodes it to a step index, counts instructions.
// One cycle: t_in sampled at edge N is visible on step/valid/clr_req after edge N.
// No backpressure; en=0 freezes every register, including a pending clr_req pulse.
module timing_monitor
    import timing_monitor_pkg::*;
#(
    parameter int MAX_STEP = 15,
    parameter int CW       = 8
) (
    input  logic                clk,
    input  logic                res,
    timing_monitor_if.slave     bus
);

    logic [3:0]    enc_idx;
    logic          enc_zero;
    logic          enc_multi;
    logic          enc_one;

    logic [1:0]    state;
    logic [3:0]    step_r;
    logic          valid_r;
    logic          err_onehot_r;
    logic          err_seq_r;
    logic [CW-1:0] instr_count_r;
    logic          clr_req_r;
    logic          step_legal;

    onehot_enc16 u_enc (
        .d        (bus.t_in),
        .idx      (enc_idx),
        .is_zero  (enc_zero),
        .is_multi (enc_multi)
    );

    assign enc_one = !enc_zero && !enc_multi;

    // A step is legal if it advances by one (with wrap), clears to T0, or a parallel load is announced.
    assign step_legal = (enc_idx == next_step(step_r)) || (enc_idx == 4'd0) || bus.jump_ok;

    // Step/valid follow every enabled sample regardless of state; zero/multi samples hold the step.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            step_r  <= 4'd0;
            valid_r <= 1'b0;
        end else if (bus.en) begin
            if (enc_one) begin
                step_r  <= enc_idx;
                valid_r <= 1'b1;
            end else begin
                valid_r <= 1'b0;
            end
        end
    end

    // Sequence checker: state, sticky error flags, instruction counter and the clear-request pulse.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state         <= ST_IDLE;
            err_onehot_r  <= 1'b0;
            err_seq_r     <= 1'b0;
            instr_count_r <= '0;
            clr_req_r     <= 1'b0;
        end else if (bus.en) begin
            clr_req_r <= 1'b0;
            if (bus.err_clr) begin
                // Clearing wins over any error raised by this same sample.
                err_onehot_r <= 1'b0;
                err_seq_r    <= 1'b0;
                state        <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enc_multi) begin
                            err_onehot_r <= 1'b1;
                            state        <= ST_FAULT;
                        end else if (enc_one) begin
                            // First valid step after idle is taken on trust.
                            state <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (enc_multi) begin
                            err_onehot_r <= 1'b1;
                            state        <= ST_FAULT;
                        end else if (enc_one) begin
                            if (step_legal) begin
                                if ((enc_idx == 4'd0) && (step_r != 4'd0)) begin
                                    instr_count_r <= instr_count_r + 1'b1;
                                end
                                if (enc_idx == 4'(MAX_STEP)) begin
                                    clr_req_r <= 1'b1;
                                end
                            end else begin
                                err_seq_r <= 1'b1;
                                state     <= ST_FAULT;
                            end
                        end
                        // A zero sample is a decoder gap: hold everything.
                    end
                    ST_FAULT: begin
                        if (enc_multi) begin
                            err_onehot_r <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.step        = step_r;
    assign bus.valid       = valid_r;
    assign bus.err_onehot  = err_onehot_r;
    assign bus.err_seq     = err_seq_r;
    assign bus.instr_count = instr_count_r;
    assign bus.clr_req     = clr_req_r;

endmodule

// File: tb/tb_timing_monitor.sv
// Directed bench for timing_monitor with a behavioural reference model and per-cycle compare.
module tb_timing_monitor;

    localparam int MAXS = 15;
    localparam int CWB  = 8;

    logic clk;
    logic res;
    int   total;
    int   bad;
    bit   cmp_on;

    timing_monitor_if #(.CW(CWB)) bus ();

    timing_monitor #(.MAX_STEP(MAXS), .CW(CWB)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 = waiting for first step, 1 = locked on sequence, 2 = broken
    int m_mode;
    int m_step;
    bit m_valid;
    bit m_eoh;
    bit m_eseq;
    int m_cnt;
    bit m_pulse;
    int pc;
    int k;

    always @(posedge clk or negedge res) begin
        if (!res) begin
            m_mode = 0; m_step = 0; m_valid = 0; m_eoh = 0; m_eseq = 0; m_cnt = 0; m_pulse = 0;
        end else if (bus.en) begin
            pc = $countones(bus.t_in);
            k = 0;
            for (int i = 0; i < 16; i++) if (bus.t_in[i]) k = i;
            m_pulse = 0;
            if (bus.err_clr) begin
                m_eoh = 0; m_eseq = 0; m_mode = 0;
            end else if (pc > 1) begin
                if (m_mode != 2 || !m_eoh) m_eoh = 1;
                m_mode = 2;
            end else if (pc == 1 && m_mode == 0) begin
                m_mode = 1;
            end else if (pc == 1 && m_mode == 1) begin
                if (k == (m_step + 1) % 16 || k == 0 || bus.jump_ok) begin
                    if (k == 0 && m_step != 0) m_cnt = (m_cnt + 1) % (1 << CWB);
                    if (k == MAXS) m_pulse = 1;
                end else begin
                    m_eseq = 1;
                    m_mode = 2;
                end
            end
            if (pc == 1) begin
                m_step = k;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (res === 1'b1 && cmp_on) begin
            chk("step",        int'(bus.step),        m_step);
            chk("valid",       int'(bus.valid),       int'(m_valid));
            chk("err_onehot",  int'(bus.err_onehot),  int'(m_eoh));
            chk("err_seq",     int'(bus.err_seq),     int'(m_eseq));
            chk("instr_count", int'(bus.instr_count), m_cnt);
            chk("clr_req",     int'(bus.clr_req),     int'(m_pulse));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [15:0] t, input logic j = 1'b0, input logic e = 1'b1, input logic c = 1'b0);
        bus.t_in    = t;
        bus.jump_ok = j;
        bus.en      = e;
        bus.err_clr = c;
        @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_step"},  int'(bus.step), 0);
        chk({tag, "_valid"}, int'(bus.valid), 0);
        chk({tag, "_eoh"},   int'(bus.err_onehot), 0);
        chk({tag, "_eseq"},  int'(bus.err_seq), 0);
        chk({tag, "_cnt"},   int'(bus.instr_count), 0);
        chk({tag, "_clr"},   int'(bus.clr_req), 0);
    endtask

    task automatic do_reset();
        res = 1'b0;
        bus.t_in = '0; bus.jump_ok = 1'b0; bus.en = 1'b0; bus.err_clr = 1'b0;
        @(negedge clk);
        all_zero("rst");
        res = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; cmp_on = 1'b1;
        res = 1'b0;
        bus.t_in = '0; bus.jump_ok = 1'b0; bus.en = 1'b0; bus.err_clr = 1'b0;
        @(negedge clk);

        // Clean run T0..T15, T0
        do_reset();
        for (int i = 0; i < 15; i++) cyc(16'(1 << i));
        chk("run_clr_before", int'(bus.clr_req), 0);
        cyc(16'h8000);
        chk("run_step15", int'(bus.step), 15);
        chk("run_clr15", int'(bus.clr_req), 1);
        cyc(16'h0001);
        chk("run_cnt", int'(bus.instr_count), 1);
        chk("run_clr_after", int'(bus.clr_req), 0);
        chk("run_eseq", int'(bus.err_seq), 0);

        // Clear mid-instruction
        do_reset();
        for (int i = 0; i < 6; i++) cyc(16'(1 << i));
        cyc(16'h0001);
        chk("mid_cnt", int'(bus.instr_count), 1);
        chk("mid_eseq", int'(bus.err_seq), 0);

        // Parallel load
        do_reset();
        for (int i = 0; i < 4; i++) cyc(16'(1 << i));
        cyc(16'h0400, 1'b1);
        chk("jmp_step", int'(bus.step), 10);
        chk("jmp_eseq", int'(bus.err_seq), 0);
        cyc(16'h0001);
        for (int i = 1; i < 4; i++) cyc(16'(1 << i));
        cyc(16'h0400, 1'b0);
        chk("bad_jmp_eseq", int'(bus.err_seq), 1);
        chk("bad_jmp_step", int'(bus.step), 10);
        for (int i = 11; i < 16; i++) cyc(16'(1 << i));
        chk("fault_no_clr", int'(bus.clr_req), 0);
        cyc(16'h0001);
        chk("fault_no_cnt", int'(bus.instr_count), 1);

        // Non-one-hot, err_clr, re-acquire
        do_reset();
        cyc(16'h0010);
        cyc(16'h0005);
        chk("oh_eoh", int'(bus.err_onehot), 1);
        chk("oh_valid", int'(bus.valid), 0);
        chk("oh_step", int'(bus.step), 4);
        cyc(16'h0000, 1'b0, 1'b1, 1'b1);
        chk("clr_eoh", int'(bus.err_onehot), 0);
        cyc(16'h0080);
        chk("reacq_step", int'(bus.step), 7);
        chk("reacq_eseq", int'(bus.err_seq), 0);
        cyc(16'h0100);
        cyc(16'h0008);
        chk("track_eseq", int'(bus.err_seq), 1);
        cyc(16'h00FF, 1'b0, 1'b1, 1'b1);
        chk("clr_prio_eoh", int'(bus.err_onehot), 0);
        chk("clr_prio_eseq", int'(bus.err_seq), 0);

        // Gaps and en=0
        do_reset();
        cyc(16'h0004);
        cyc(16'h0000);
        chk("gap_valid", int'(bus.valid), 0);
        chk("gap_step", int'(bus.step), 2);
        cyc(16'h0000);
        cyc(16'h0008);
        chk("gap_eseq", int'(bus.err_seq), 0);
        chk("gap_step3", int'(bus.step), 3);
        cyc(16'hFFFF, 1'b0, 1'b0);
        cyc(16'h0000, 1'b0, 1'b0);
        chk("en0_eoh", int'(bus.err_onehot), 0);
        chk("en0_step", int'(bus.step), 3);
        chk("en0_valid", int'(bus.valid), 1);
        for (int i = 4; i < 16; i++) cyc(16'(1 << i));
        cyc(16'h0000, 1'b0, 1'b0);
        chk("en0_clr_hold", int'(bus.clr_req), 1);
        cyc(16'h0000);
        chk("gap_no_repulse", int'(bus.clr_req), 0);
        cyc(16'h0000);
        chk("gap15_step", int'(bus.step), 15);

        // Async reset mid-run
        do_reset();
        for (int r = 0; r < 3; r++) for (int i = 0; i < 16; i++) cyc(16'(1 << i));
        for (int i = 0; i < 10; i++) cyc(16'(1 << i));
        chk("pre_rst_step", int'(bus.step), 9);
        chk("pre_rst_cnt", int'(bus.instr_count), 3);
        #2 res = 1'b0;
        #1 all_zero("arst");
        @(negedge clk);
        res = 1'b1;
        cyc(16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timing_monitor.md
Name: timing_monitor

Overview:
- Receiving end of the sequencer's one-hot timing bus (T0..T15).
- Re-encodes the bus into a registered 4-bit step index and checks that it is one-hot.
- Checks that steps advance legally: +1, clear to T0, or an announced parallel load.
- Counts completed instruction cycles and raises a registered clear request when the last control step of an instruction is reached.

Parameters:
- MAX_STEP, 15: step index at which clr_req is pulsed. Range 1..15.
- CW, 8: width of instr_count.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- res, input, 1: asynchronous, active-low reset (0 = reset).
- en, input, 1: sample enable. When 0, all state holds and no checks run.
- t_in, input, 16: one-hot timing bus from the sequencer. Bit k = Tk.
- jump_ok, input, 1: a sequencer parallel load is in effect this cycle. Any nonzero step is accepted.
- err_clr, input, 1: clears the sticky error flags and returns the state machine to IDLE.
- step, output, 4: registered binary index of the last valid one-hot t_in.
- valid, output, 1: the last sample was exactly one-hot.
- err_onehot, output, 1: sticky. Set when t_in had 2 or more bits set.
- err_seq, output, 1: sticky. Set on an illegal step transition.
- instr_count, output, CW: number of entries into T0 from a nonzero step. Wraps modulo 2^CW.
- clr_req, output, 1: one-cycle pulse when step becomes MAX_STEP in TRACK.

Behaviour:
- Reset (res=0, asynchronous):
  - step=0, valid=0, err_onehot=0, err_seq=0, instr_count=0, clr_req=0.
  - State goes to IDLE.
  - Reset asserted mid-operation discards everything immediately.
- Latency: t_in sampled at edge N appears on step/valid after edge N. clr_req is registered in the same edge.
- Classification of a sample with en=1:
  - ZERO: popcount 0.
  - ONE: popcount 1. Encoded index is k.
  - MULTI: popcount 2 or more.
- States and transitions:
  - IDLE:
    - ZERO: valid=0, stay in IDLE.
    - ONE: step=k, valid=1, go to TRACK. No sequence check and no count.
    - MULTI: valid=0, err_onehot=1, go to FAULT.
  - TRACK (prev = current step):
    - ZERO: valid=0, step holds, state holds. This is a decoder-disabled gap and is not an error. The next ONE is checked against the held prev.
    - ONE, legal if any of the following:
      - k = prev+1 mod 16 (15->0 wrap is legal).
      - k = 0 (sequencer clear).
      - jump_ok=1 (any k).
    - Legal ONE: step=k, valid=1. If k=0 and prev≠0, instr_count increments.
    - Illegal ONE, including k = prev without jump_ok: step=k, valid=1, err_seq=1, go to FAULT.
    - MULTI: valid=0, step holds, err_onehot=1, go to FAULT.
  - FAULT:
    - step and valid keep tracking ONE/ZERO samples.
    - No checks run, no counting, clr_req is held 0.
    - MULTI keeps err_onehot set.
- err_clr:
  - Applies in any state.
  - Clears both sticky flags and goes to IDLE on the next edge.
  - Has priority over setting an error in the same cycle.
  - Does not change step, valid or instr_count.
- clr_req:
  - 1 for exactly one cycle when a legal ONE with k=MAX_STEP is accepted in TRACK.
  - Otherwise 0.
  - Holding at MAX_STEP through ZERO gaps does not re-pulse.
- en=0: every register holds, including clr_req. A pulse already high stays high until the next enabled edge. A level change on t_in is ignored.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, TRACK=2'd1, FAULT=2'd2) and the constant NSTEPS=16, shared with the sequencer.
- One sub-module, onehot_enc16:
  - Combinational. Input 16-bit, outputs idx[3:0], is_zero, is_multi.
  - Reusable wherever the timing bus is consumed.

Test Plan:
- Reset then a clean run: t_in = 1<<0, 1<<1, … 1<<15, 1<<0, one per clk, en=1 -> step follows 1 cycle late; valid=1; clr_req high only the cycle step=15; instr_count=1; no errors.
- Clear mid-instruction: T0..T5, then T0 -> legal; instr_count increments to 1; err_seq=0.
- Parallel load: from T3, t_in=1<<10 with jump_ok=1 -> step=10, no error. Repeat with jump_ok=0 -> err_seq=1, state FAULT, subsequent steps not counted.
- Non-one-hot: t_in=16'h0005 -> err_onehot=1, valid=0, step holds. err_clr pulse -> flags 0, IDLE; next T7 accepted without a check.
- Gaps and en: T2, 0, 0, T3 -> no error, valid low during the gap. en=0 while t_in changes to 0xFFFF -> no flags, outputs frozen.
- Async reset mid-run at step=9, instr_count=3: drop res between clock edges -> all outputs 0 immediately, with no clock edge needed.
